imem_loader_responder: RTL and testbench
========================================

# imem_loader_responder

Instruction-memory responder serving the fetch stage's 32-bit instruction read port, with a byte-stream program loader that fills the memory before execution. Fetch presents a byte address and receives, in the same cycle, the aligned 32-bit word containing it. RV32C halfword selection and buffering remain in fetch. A loader FSM assembles little-endian bytes into words, writes them sequentially from word 0, and holds fetch off with NOPs while loading.

## Interface
Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words (power of two, ≥ 4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- address  in  32  fetch byte address
- data  out  32 (instruction_type)  word at address[31:2]
- load_valid  in  1  loader byte valid
- load_byte  in  8  loader byte
- load_ready  out  1  loader may accept a byte this cycle
- busy  out  1  load in progress; fetch/PC must stall
- load_done  out  1  one-cycle pulse at load completion
- load_error  out  1  sticky: header word count exceeded MEM_WORDS

## Operation
- Read path is combinational. data = mem[address[$clog2(MEM_WORDS)+1:2]] when address[31:2] < MEM_WORDS and busy = 0. Otherwise data = NOP_INSTR (32'h00000013). address[1:0] is ignored.
- A byte transfer occurs when load_valid && load_ready.
- FSM states:
  - IDLE: first accepted byte → HEADER.
  - HEADER: collects the 4-byte little-endian word count N. First byte = N[7:0].
  - DATA: collects 4·N bytes, little-endian per word.
  - DONE: one cycle, then → IDLE.
- HEADER exit:
  - N == 0 → DONE directly.
  - N > MEM_WORDS → set load_error, then enter DATA.
- DATA: the 4th byte of each word writes mem[word_ptr], then word_ptr++.
  - Writes with word_ptr ≥ MEM_WORDS are dropped; bytes are still consumed.
  - After word N is written → DONE.
- load_ready = 1 in IDLE/HEADER/DATA, 0 in DONE and during reset.
- busy = (state ≠ IDLE).
- load_done = 1 only in DONE.
- load_error clears on reset or on the first accepted byte of a new load. Otherwise it holds.
- Byte counter (2 bits) wraps every 4 bytes. word_ptr and the N comparison are 32 bits wide; there is no wrap into low memory.

## Timing
- Reset (reset_n low at an edge) gives: state IDLE, word_ptr 0, byte counter 0, assembled partial word 0, load_error 0.
  - Resulting outputs: busy 0, load_done 0, load_ready 1 from the first cycle after reset releases.
  - Memory contents are not cleared.
- Reset mid-load aborts: the partial word is discarded, words already written remain, and no load_done pulse is produced.
- Read latency is 0 cycles: data follows address within the same cycle.
- busy rises the cycle after the first header byte is accepted.
- A word written at edge k is visible on data from cycle k+1. It is masked as NOP until busy = 0.
- Last data byte accepted at edge k:
  - Cycle k+1: DONE, load_done = 1, busy = 1, load_ready = 0.
  - Cycle k+2: IDLE, busy = 0.
- N == 0: 4th header byte at edge k → DONE in cycle k+1.
- load_valid while load_ready = 0: the byte is not consumed, and the source holds it.

## Structure
- common package additions:
  - NOP_INSTR constant.
  - loader_state_type enum {IDLE, HEADER, DATA, DONE}.
- Single module with memory inferred inline (distributed RAM, asynchronous read, synchronous write).
- No sub-module. The byte-assembly shift register is ~10 lines and stays local.

## Test plan
- Reset, then address 0x0 with memory preloaded 0x00B50533 at word 0 → data = 0x00B50533, busy 0, load_ready 1.
- Stream 02 00 00 00, 93 00 10 00, 13 01 20 00 back-to-back → mem[0] = 0x00100093, mem[1] = 0x00200113. load_done pulses once, 1 cycle after the last byte. busy is low one cycle later. Data reads NOP while busy.
- Header N = 0 → DONE the cycle after the 4th header byte, no memory write, load_error 0.
- N = MEM_WORDS+1 → load_error = 1 after the header. All bytes accepted, words 0..MEM_WORDS−1 written, last word dropped, load_done pulses.
- Assert reset_n low after 6 data bytes of a 2-word load, then reload 1 word 0xDEADBEEF → word 0 = 0xDEADBEEF, word 1 unchanged, no stale partial bytes.
- Address 0x0000_0006 and out-of-range address MEM_WORDS·4 → word 1 returned and 0x00000013 respectively. Random load_valid gaps produce identical memory contents.

Source files
------------

// File: rtl/imem_loader_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader_responder_pkg : shared types/constants for the imem loader   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package imem_loader_responder_pkg;

    typedef logic [31:0] instruction_type;

    localparam instruction_type NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } loader_state_type;

endpackage
`default_nettype wire

// File: rtl/imem_loader_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader_responder : combinational instruction fetch port plus a      |
// | little-endian byte-stream loader that fills memory from word 0.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_loader_responder
    import imem_loader_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    output logic [31:0] data,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int          ADDR_W = $clog2(MEM_WORDS);
    localparam logic [31:0] DEPTH  = 32'(MEM_WORDS);

    logic [31:0]      mem [MEM_WORDS];
    loader_state_type state;
    loader_state_type next_state;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift_word;
    logic [31:0]      word_ptr;
    logic [31:0]      word_count;
    logic [31:0]      assembled;
    logic             accept;
    logic             word_done;
    logic             in_range;
    logic             unused_addr_bits;

    assign accept    = load_valid && load_ready;
    // Newest byte lands on top so the first byte of a word ends up in [7:0].
    assign assembled = {load_byte, shift_word};
    assign word_done = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = HEADER;
                end
            end
            HEADER: begin
                if (word_done) begin
                    next_state = (assembled == 32'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (word_done && ((word_ptr + 32'd1) == word_count)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        load_ready = reset_n && (state != DONE);
        load_done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_cnt   <= 2'd0;
            shift_word <= 24'd0;
            word_ptr   <= 32'd0;
            word_count <= 32'd0;
            load_error <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt   <= byte_cnt + 2'd1;
                shift_word <= assembled[31:8];
            end
            if ((state == IDLE) && accept) begin
                load_error <= 1'b0;
                word_ptr   <= 32'd0;
            end
            if ((state == HEADER) && word_done) begin
                word_count <= assembled;
                if (assembled > DEPTH) begin
                    load_error <= 1'b1;
                end
            end
            if ((state == DATA) && word_done) begin
                word_ptr <= word_ptr + 32'd1;
            end
        end
    end

    // Words past the end of memory are consumed but never written.
    always_ff @(posedge clk) begin
        if ((state == DATA) && word_done && (word_ptr < DEPTH)) begin
            mem[word_ptr[ADDR_W-1:0]] <= assembled;
        end
    end

    assign in_range         = ({2'b00, address[31:2]} < DEPTH);
    assign data             = (in_range && !busy) ? mem[address[ADDR_W+1:2]] : NOP_INSTR;
    assign unused_addr_bits = ^address[1:0];

endmodule
`default_nettype wire

// File: tb/tb_imem_loader_responder.sv
`default_nettype none
// Randomized scoreboard bench for imem_loader_responder against a
// word-level memory model.
module tb_imem_loader_responder;

    localparam int          MEM_WORDS = 8;
    localparam int          ADDR_W    = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] data;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          neg_cnt   = 0;
    done_t       done_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_mem [MEM_WORDS];

    imem_loader_responder #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .data       (data),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected responses whenever the DUT presents them.
    initial begin
        logic  prev_done;
        done_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (busy) begin
                chk("nop_while_busy", data, NOP);
            end
            if (prev_done) begin
                chk("busy_low_after_done", {31'b0, busy}, 32'd0);
            end
            if (load_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {31'b0, load_done}, 32'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", neg_cnt, e.cyc);
                    chk("done_error", {31'b0, load_error}, {31'b0, e.err});
                    chk("ready_in_done", {31'b0, load_ready}, 32'd0);
                    chk("busy_in_done", {31'b0, busy}, 32'd1);
                end
            end
            prev_done = load_done;
            if (rd_q.size() != 0) begin
                chk("read_data", data, rd_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic push_done, input logic exp_err);
        int    guard;
        done_t e;
        guard      = 0;
        load_valid = 1'b1;
        load_byte  = b;
        while (!load_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                $display("FAIL load_ready_timeout: ready low for %0d cycles, required high", guard);
                $fatal(1, "loader stalled");
            end
        end
        @(posedge clk);
        if (push_done) begin
            e.cyc = neg_cnt + 1;
            e.err = exp_err;
            done_q.push_back(e);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] n, input logic [31:0] w[$],
                           input int gap_max, input int max_bytes);
        logic [7:0] bytes[$];
        logic       err;
        int         total;
        err = (n > MEM_WORDS);
        for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
        foreach (w[j]) begin
            for (int i = 0; i < 4; i++) bytes.push_back(w[j][8*i +: 8]);
        end
        total = (max_bytes < bytes.size()) ? max_bytes : bytes.size();
        chk("busy_before_load", {31'b0, busy}, 32'd0);
        for (int k = 0; k < total; k++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(bytes[k], (k == int'(bytes.size()) - 1), err);
            if (k == 0) begin
                chk("busy_rise", {31'b0, busy}, 32'd1);
                chk("error_cleared", {31'b0, load_error}, 32'd0);
            end
            if (k == 3) begin
                chk("error_after_header", {31'b0, load_error}, {31'b0, err});
            end
        end
        if (total == bytes.size()) begin
            for (int j = 0; j < int'(n); j++) begin
                if (j < MEM_WORDS) model_mem[j] = w[j];
            end
            @(negedge clk);
        end else if (total >= 4) begin
            for (int j = 0; j < (total - 4) / 4; j++) model_mem[j] = w[j];
        end
    endtask

    task automatic check_read(input logic [31:0] a);
        @(posedge clk);
        #1;
        address = a;
        rd_q.push_back(((a >> 2) < MEM_WORDS) ? model_mem[a[ADDR_W+1:2]] : NOP);
        @(negedge clk);
    endtask

    task automatic do_reset();
        load_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk("ready_in_reset", {31'b0, load_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ready", {31'b0, load_ready}, 32'd1);
        chk("reset_done", {31'b0, load_done}, 32'd0);
        chk("reset_error", {31'b0, load_error}, 32'd0);
    endtask

    initial begin
        logic [31:0] w[$];
        int          n;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'd0;
        address    = 32'd0;
        do_reset();

        w.delete(); w.push_back(32'h00B5_0533);
        do_load(1, w, 0, 1000);
        check_read(32'h0);

        w.delete(); w.push_back(32'h0010_0093); w.push_back(32'h0020_0113);
        do_load(2, w, 0, 1000);
        check_read(32'h0);
        check_read(32'h4);
        check_read(32'h6);

        w.delete();
        do_load(0, w, 0, 1000);
        check_read(32'h0);
        check_read(32'h4);

        // Overflowing header: every word is consumed, the last one dropped.
        w.delete();
        for (int i = 0; i < MEM_WORDS + 1; i++) w.push_back($urandom);
        do_load(MEM_WORDS + 1, w, 2, 1000);
        for (int i = 0; i < MEM_WORDS; i++) check_read(32'(i * 4));
        check_read(32'(MEM_WORDS * 4));

        // Abort after 6 data bytes, then reload a single word.
        w.delete(); w.push_back($urandom); w.push_back($urandom);
        do_load(2, w, 1, 10);
        do_reset();
        w.delete(); w.push_back(32'hDEAD_BEEF);
        do_load(1, w, 0, 1000);
        check_read(32'h0);
        check_read(32'h4);

        repeat (6) begin
            n = $urandom_range(1, MEM_WORDS);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            do_load(n, w, 3, 1000);
            for (int i = 0; i < MEM_WORDS; i++) check_read(32'(i * 4));
            repeat (3) check_read($urandom_range(0, MEM_WORDS * 4 - 1));
            repeat (2) check_read($urandom);
        end

        repeat (3) @(negedge clk);
        chk("done_queue_drained", done_q.size(), 32'd0);
        chk("read_queue_drained", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
